cache_ctrl: RTL

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_pkg.sv | 29 ++
 rtl/cache_tag_array.sv | 73 +++++++
 rtl/cache_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - geometry constants, FSM state enum and line-state struct for cache_ctrl
// Ports: none (package).
package cache_pkg;

    localparam int SETS   = 8;
    localparam int WAYS   = 4;
    localparam int WORDS  = 16;
    localparam int TAG_W  = 5;
    localparam int ADDR_W = 12;
    localparam int SET_W  = 3;
    localparam int WAY_W  = 2;
    localparam int OFF_W  = 4;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL,
        RESP
    } state_t;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } line_t;

endpackage

// File: rtl/cache_tag_array.sv
// rtl/cache_tag_array.sv - valid/dirty/tag storage and per-set round-robin victim pointers
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   lookup_set, lookup_tag        combinational lookup key
//   hit, hit_way                  lookup result
//   victim_way, victim_line       round-robin victim of lookup_set and its current state
//   wr_en, wr_set, wr_way, wr_line  synchronous line-state update
//   rr_adv, rr_set                advance the round-robin pointer of rr_set
module cache_tag_array
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [SET_W-1:0] lookup_set,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit,
    output logic [WAY_W-1:0] hit_way,
    output logic [WAY_W-1:0] victim_way,
    output line_t            victim_line,
    input  logic             wr_en,
    input  logic [SET_W-1:0] wr_set,
    input  logic [WAY_W-1:0] wr_way,
    input  line_t            wr_line,
    input  logic             rr_adv,
    input  logic [SET_W-1:0] rr_set
);

    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [WAY_W-1:0] rr_q    [SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            if (wr_en) begin
                valid_q[wr_set][wr_way] <= wr_line.valid;
                dirty_q[wr_set][wr_way] <= wr_line.dirty;
            end
            if (rr_adv) begin
                rr_q[rr_set] <= rr_q[rr_set] + WAY_W'(1);
            end
        end
    end

    // Tags are meaningless while valid=0, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_set][wr_way] <= wr_line.tag;
        end
    end

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lookup_set][w] && (tag_q[lookup_set][w] == lookup_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        victim_way        = rr_q[lookup_set];
        victim_line.valid = valid_q[lookup_set][victim_way];
        victim_line.dirty = dirty_q[lookup_set][victim_way];
        victim_line.tag   = tag_q[lookup_set][victim_way];
    end

endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - 4-way write-back cache controller with 16-word line refill/writeback
// Ports:
//   clk, rst                                   clock, synchronous active-high reset
//   req_valid/req_ready/req_we/req_addr/req_wdata  CPU request (one outstanding)
//   resp_valid/resp_hit/resp_rdata             one-cycle completion
//   da_set/da_way/da_off/da_we/da_wdata/da_rdata   external data array (combinational read)
//   mem_valid/mem_we/mem_addr/mem_wdata/mem_ready/mem_rdata  word-wide backing memory
module cache_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [SET_W-1:0]  da_set,
    output logic [WAY_W-1:0]  da_way,
    output logic [OFF_W-1:0]  da_off,
    output logic              da_we,
    output logic [DATA_W-1:0] da_wdata,
    input  logic [DATA_W-1:0] da_rdata,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t state, state_nx;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              first_q;
    logic [WAY_W-1:0]  vway_q;
    logic [TAG_W-1:0]  vtag_q;
    logic [OFF_W-1:0]  cnt_q;
    logic              resp_hit_q;
    logic [DATA_W-1:0] resp_rdata_q;

    logic [SET_W-1:0]  req_set;
    logic [TAG_W-1:0]  req_tag;
    logic [OFF_W-1:0]  req_off;

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim_way;
    line_t             victim_line;
    logic              tag_wr_en;
    logic [WAY_W-1:0]  tag_wr_way;
    line_t             tag_wr_line;
    logic              rr_adv;

    logic              mem_hs;
    logic              last_word;

    assign req_off   = addr_q[OFF_W-1:0];
    assign req_set   = addr_q[OFF_W +: SET_W];
    assign req_tag   = addr_q[OFF_W+SET_W +: TAG_W];
    assign mem_hs    = mem_valid & mem_ready;
    assign last_word = (cnt_q == OFF_W'(WORDS-1));

    assign resp_hit   = resp_hit_q;
    assign resp_rdata = resp_rdata_q;

    cache_tag_array u_tags (
        .clk         (clk),
        .rst         (rst),
        .lookup_set  (req_set),
        .lookup_tag  (req_tag),
        .hit         (hit),
        .hit_way     (hit_way),
        .victim_way  (victim_way),
        .victim_line (victim_line),
        .wr_en       (tag_wr_en),
        .wr_set      (req_set),
        .wr_way      (tag_wr_way),
        .wr_line     (tag_wr_line),
        .rr_adv      (rr_adv),
        .rr_set      (req_set)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (req_valid) state_nx = LOOKUP;
            LOOKUP: begin
                if (hit) begin
                    state_nx = RESP;
                end else if (victim_line.valid && victim_line.dirty) begin
                    state_nx = WRITEBACK;
                end else begin
                    state_nx = REFILL;
                end
            end
            WRITEBACK: if (mem_hs && last_word) state_nx = REFILL;
            REFILL:    if (mem_hs && last_word) state_nx = LOOKUP;
            RESP:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Output / strobe logic
    always_comb begin
        req_ready   = (state == IDLE);
        resp_valid  = (state == RESP);
        mem_valid   = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = {addr_q[ADDR_W-1:OFF_W], cnt_q};
        mem_wdata   = da_rdata;
        da_set      = req_set;
        da_way      = vway_q;
        da_off      = cnt_q;
        da_we       = 1'b0;
        da_wdata    = mem_rdata;
        tag_wr_en   = 1'b0;
        tag_wr_way  = vway_q;
        tag_wr_line = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
        rr_adv      = 1'b0;
        case (state)
            LOOKUP: begin
                da_off   = req_off;
                da_wdata = wdata_q;
                if (hit) begin
                    da_way      = hit_way;
                    da_we       = we_q;
                    tag_wr_en   = we_q;
                    tag_wr_way  = hit_way;
                    tag_wr_line = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
                end else begin
                    // Drop the victim now so an aborted refill never leaves a
                    // stale tag pointing at half-overwritten data.
                    rr_adv      = 1'b1;
                    tag_wr_en   = 1'b1;
                    tag_wr_way  = victim_way;
                    tag_wr_line = '{valid: 1'b0, dirty: 1'b0, tag: victim_line.tag};
                end
            end
            WRITEBACK: begin
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {vtag_q, req_set, cnt_q};
            end
            REFILL: begin
                mem_valid = 1'b1;
                da_we     = mem_ready;
                if (mem_ready && last_word) begin
                    tag_wr_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Request latch, word counter and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            first_q      <= 1'b0;
            vway_q       <= '0;
            vtag_q       <= '0;
            cnt_q        <= '0;
            resp_hit_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        first_q <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        resp_hit_q   <= first_q;
                        resp_rdata_q <= we_q ? wdata_q : da_rdata;
                    end else begin
                        first_q <= 1'b0;
                        vway_q  <= victim_way;
                        vtag_q  <= victim_line.tag;
                        cnt_q   <= '0;
                    end
                end
                WRITEBACK, REFILL: begin
                    if (mem_hs) begin
                        cnt_q <= cnt_q + OFF_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
